// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped write-through cache controller with multi-word refill and saturating hit/miss counters.
// Define CACHE_WRITE_ALLOC_EN for write-allocate; otherwise write misses bypass the arrays.
module cache_ctrl_fsm #(
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  output logic              cpu_ack,
  output logic              busy,
  output logic              tag_rd_en,
  output logic              data_rd_en,
  input  logic              tag_hit,
  output logic              tag_we,
  output logic              data_we,
  output logic              data_src_cpu,
  output logic [IDX_W-1:0]  refill_idx,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_rdy,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] miss_cnt,
  output logic [2:0]        state_o
);

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_TAG    = 3'b001;
  localparam logic [2:0] S_CMP    = 3'b010;
  localparam logic [2:0] S_REFILL = 3'b011;
  localparam logic [2:0] S_WT     = 3'b100;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_WORDS - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              r_op_we;
  logic              r_retry;
  logic [IDX_W-1:0]  r_refill_idx;
  logic [STAT_W-1:0] r_hit_cnt;
  logic [STAT_W-1:0] r_miss_cnt;
  logic              w_refill_beat;
  logic              w_last_beat;
  logic              w_hit_evt;
  logic              w_miss_evt;

  assign w_refill_beat = (r_state == S_REFILL) && mem_rdy;
  assign w_last_beat   = w_refill_beat && (r_refill_idx == LAST_IDX);
  // Retried lookups after a refill are not new accesses, so they never count.
  assign w_hit_evt     = (r_state == S_CMP) && !r_retry && tag_hit;
  assign w_miss_evt    = (r_state == S_CMP) && !r_retry && !tag_hit;

  always_comb begin
    w_next       = r_state;
    cpu_ack      = 1'b0;
    tag_rd_en    = 1'b0;
    data_rd_en   = 1'b0;
    tag_we       = 1'b0;
    data_we      = 1'b0;
    data_src_cpu = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) w_next = S_TAG;
      end
      S_TAG: begin
        tag_rd_en  = 1'b1;
        data_rd_en = !r_op_we;
        w_next     = S_CMP;
      end
      S_CMP: begin
        if (tag_hit) begin
          if (r_op_we) begin
            data_we      = 1'b1;
            data_src_cpu = 1'b1;
            w_next       = S_WT;
          end else begin
            cpu_ack = 1'b1;
            w_next  = S_IDLE;
          end
        end else begin
`ifdef CACHE_WRITE_ALLOC_EN
          w_next = S_REFILL;
`else
          w_next = r_op_we ? S_WT : S_REFILL;
`endif
        end
      end
      S_REFILL: begin
        mem_req = 1'b1;
        data_we = mem_rdy;
        tag_we  = w_last_beat;
        if (w_last_beat) w_next = S_TAG;
      end
      S_WT: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_rdy) begin
          cpu_ack = 1'b1;
          w_next  = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_op_we      <= 1'b0;
      r_retry      <= 1'b0;
      r_refill_idx <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && cpu_req) begin
        r_op_we <= cpu_we;
        r_retry <= 1'b0;
      end
      if (r_state == S_CMP) begin
        r_refill_idx <= '0;
      end else if (w_refill_beat) begin
        if (w_last_beat) begin
          r_refill_idx <= '0;
          r_retry      <= 1'b1;
        end else begin
          r_refill_idx <= r_refill_idx + IDX_W'(1);
        end
      end
      // Clear takes priority over any increment in the same cycle.
      if (stat_clr) begin
        r_hit_cnt  <= '0;
        r_miss_cnt <= '0;
      end else begin
        if (w_hit_evt && r_hit_cnt != STAT_MAX)   r_hit_cnt  <= r_hit_cnt + STAT_W'(1);
        if (w_miss_evt && r_miss_cnt != STAT_MAX) r_miss_cnt <= r_miss_cnt + STAT_W'(1);
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign refill_idx = r_refill_idx;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;
  assign state_o    = r_state;

endmodule

// File: doc/cache_ctrl_fsm.md
Name: cache_ctrl_fsm

Overview:
- Parametrised controller for a direct-mapped, write-through cache.
- Sits between the CPU request interface, the tag/data arrays and main memory.
- Adds three things to our fixed single-word controller: multi-word line refill with a beat counter, a ready-handshaked memory port, and saturating hit/miss statistics.
- Write-miss policy is selectable at compile time.

Parameters:
- LINE_WORDS, 4, words per cache line; power of 2, >=1
- IDX_W, max(1,$clog2(LINE_WORDS)), refill_idx width
- STAT_W, 16, width of the hit/miss counters

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU request; accepted only in IDLE
- cpu_we  in  1  1=write, 0=read; sampled only on acceptance
- cpu_ack  out  1  one-cycle pulse when the request completes
- busy  out  1  high whenever state is not IDLE
- tag_rd_en  out  1  tag array read enable
- data_rd_en  out  1  data array read enable
- tag_hit  in  1  tag compare result; valid only in CMP
- tag_we  out  1  writes tag+valid for the line being refilled
- data_we  out  1  data array write enable
- data_src_cpu  out  1  data-array write source: 1=CPU, 0=memory
- refill_idx  out  IDX_W  word index within the line during refill
- mem_req  out  1  memory request, held until beat accepted
- mem_we  out  1  1=write-through beat, 0=refill read beat
- mem_rdy  in  1  memory beat accepted/returned this cycle
- stat_clr  in  1  clears both counters
- hit_cnt  out  STAT_W  saturating hit count
- miss_cnt  out  STAT_W  saturating miss count
- state_o  out  3  debug state code

Behaviour:
- Reset (synchronous): state=IDLE; op_we=0, retry=0, refill_idx=0, hit_cnt=0, miss_cnt=0. All other outputs are 0.
- Reset mid-operation aborts any transfer. mem_req is 0 in the cycle after reset is sampled. No ack is issued.
- State codes: IDLE=000, TAG=001, CMP=010, REFILL=011, WT=100.
- A beat is a cycle with mem_req && mem_rdy. mem_we is stable while mem_req is high.
- IDLE:
  - On cpu_req, latch op_we=cpu_we, clear retry, go to TAG.
  - cpu_req outside IDLE is ignored.
- TAG:
  - tag_rd_en=1; data_rd_en=!op_we.
  - Always go to CMP next cycle (tag/data arrays are synchronous).
- CMP (tag_hit is sampled here only):
  - Read hit: cpu_ack=1, go to IDLE.
  - Read miss: go to REFILL with refill_idx=0.
  - Write hit: data_we=1, data_src_cpu=1, go to WT.
  - Write miss: policy per WRITE_ALLOC_EN (see Optional Feature).
  - Counters: increment hit_cnt or miss_cnt only when retry=0. A retried lookup never counts.
- REFILL:
  - mem_req=1, mem_we=0, data_src_cpu=0.
  - data_we=mem_rdy (the beat is written the same cycle).
  - On each beat refill_idx increments.
  - On the beat with refill_idx==LINE_WORDS-1: tag_we=1, refill_idx wraps to 0, retry=1, go to TAG.
  - A miss on a retry refills again, without counting.
- WT:
  - mem_req=1, mem_we=1.
  - On the beat: cpu_ack=1, go to IDLE.
- Latency from acceptance cycle:
  - Read hit: ack in cycle +2.
  - Write hit: ack at the first mem_rdy in WT, earliest cycle +3.
- Counters:
  - Saturate at 2^STAT_W-1.
  - stat_clr wins over a simultaneous increment.
  - stat_clr has effect in every state.
- LINE_WORDS=1: refill is exactly one beat; refill_idx is constant 0.

Optional Feature:
- Macro: CACHE_WRITE_ALLOC_EN.
- Defined (write-allocate): write miss goes to REFILL. The retry lookup then hits and performs the write-hit path: data_we from the CPU, then WT.
- Undefined (no-write-allocate): write miss goes directly to WT. The cache data/tag arrays are not written.
- In both cases miss_cnt increments once.

Test Plan:
- Read hit: reset; cpu_req=1, cpu_we=0 for one cycle; tag_hit=1 in CMP -> cpu_ack at acceptance+2; hit_cnt=1, miss_cnt=0; mem_req never high.
- Read miss, LINE_WORDS=4, mem_rdy pattern 1,0,1,1,1 -> data_we pulses with refill_idx 0,1,2,3; tag_we only with idx 3; second CMP with tag_hit=1 gives cpu_ack; miss_cnt=1, hit_cnt=0.
- Write hit, mem_rdy low 3 cycles then high -> data_we=1 and data_src_cpu=1 in CMP; mem_req=1, mem_we=1 for 4 cycles; cpu_ack coincides with mem_rdy; hit_cnt=1.
- Write miss, macro undefined -> no data_we/tag_we; WT beat then ack; miss_cnt=1. Macro defined -> 4 refill beats, retry hit, data_we from CPU, WT, ack; miss_cnt=1, hit_cnt=0.
- reset=1 after the 2nd refill beat -> next cycle mem_req=0, state_o=000, refill_idx=0, counters 0; no cpu_ack.
- STAT_W=2: 5 read hits -> hit_cnt=3 (saturated). stat_clr asserted on a hit cycle -> hit_cnt=0.
